// File: rtl/byte_word_packer.sv
// Packs a stream of DATA_W-bit lanes into OUT_W-bit words, first lane in the MSBs.
// A byte marked in_last flushes a partial word; out_keep marks which lanes hold data.
module byte_word_packer #(
  parameter int DATA_W         = 8,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [DATA_W*BYTES_PER_WORD-1:0] out_data,
  output logic [BYTES_PER_WORD-1:0] out_keep,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int N     = BYTES_PER_WORD;
  localparam int OUT_W = DATA_W * BYTES_PER_WORD;
  localparam int IDX_W = $clog2(N);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state;
  logic [OUT_W-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic [OUT_W-1:0] merged;
  logic [N-1:0]     keep_next;
  logic             in_xfer;
  logic             out_xfer;
  logic             complete;

  assign out_valid = (state == HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign complete  = in_xfer && (in_last || (idx == IDX_W'(N - 1)));

  // Lanes past idx are still zero in acc, so merging only inserts the current lane.
  always_comb begin
    merged    = acc;
    keep_next = '0;
    for (int k = 0; k < N; k++) begin
      if (k == int'(idx)) merged[OUT_W-1-k*DATA_W -: DATA_W] = in_data;
      keep_next[N-1-k] = (k <= int'(idx));
    end
  end

  // A completing byte overwrites any word being taken in the same cycle, keeping HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      acc      <= '0;
      idx      <= '0;
      out_data <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
    end else if (complete) begin
      out_data <= merged;
      out_keep <= keep_next;
      out_last <= in_last;
      acc      <= '0;
      idx      <= '0;
      state    <= HOLD;
    end else begin
      if (in_xfer) begin
        acc <= merged;
        idx <= idx + IDX_W'(1);
      end
      if (out_xfer) state <= FILL;
    end
  end

endmodule

// File: tb/tb_byte_word_packer.sv
// Scoreboard bench for byte_word_packer: directed byte streams push expected words,
// a negedge monitor pops and compares on every output transfer.
module tb_byte_word_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t sb[$];
  int tests = 0;
  int failures = 0;
  int validcycles = 0;
  int stalls = 0;

  byte_word_packer #(.DATA_W(8), .BYTES_PER_WORD(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkoutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expectword(input logic [31:0] d, input logic [3:0] k, input logic l);
    word_t w;
    w.data = d;
    w.keep = k;
    w.last = l;
    sb.push_back(w);
  endtask

  // Drive one byte and hold it until accepted; caller is aligned just after a posedge.
  task automatic applystimulus(input logic [7:0] d, input logic l);
    int t;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      stalls++;
      t++;
      @(negedge clk);
    end
    if (t >= 50) begin
      tests++;
      failures++;
      $display("[TB] FAIL in_ready timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkreset(input string tag);
    @(negedge clk);
    checkoutput({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    checkoutput({tag, " out_data"}, out_data, 32'd0);
    checkoutput({tag, " out_keep"}, {28'd0, out_keep}, 32'd0);
    checkoutput({tag, " out_last"}, {31'd0, out_last}, 32'd0);
    checkoutput({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulsereset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    word_t w;
    if (!rst && out_valid) validcycles++;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL unexpected word: got %h expected none", out_data);
      end else begin
        w = sb.pop_front();
        checkoutput("word data", out_data, w.data);
        checkoutput("word keep", {28'd0, out_keep}, {28'd0, w.keep});
        checkoutput("word last", {31'd0, out_last}, {31'd0, w.last});
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkreset("reset");

    // 1: full word, out_valid for exactly one cycle
    validcycles = 0;
    expectword(32'h000102AA, 4'hF, 1'b0);
    applystimulus(8'h00, 1'b0);
    applystimulus(8'h01, 1'b0);
    applystimulus(8'h02, 1'b0);
    applystimulus(8'hAA, 1'b0);
    idle(3);
    checkoutput("t1 valid cycles", validcycles, 32'd1);

    // 2: partial flush
    expectword(32'hBB2FEE00, 4'hE, 1'b1);
    applystimulus(8'hBB, 1'b0);
    applystimulus(8'h2F, 1'b0);
    applystimulus(8'hEE, 1'b1);
    idle(2);

    // 3: backpressure holds the word, then FF restarts at lane 0
    out_ready = 1'b0;
    expectword(32'hCDDEAAF0, 4'hF, 1'b0);
    expectword(32'hFF000000, 4'h8, 1'b1);
    applystimulus(8'hCD, 1'b0);
    applystimulus(8'hDE, 1'b0);
    applystimulus(8'hAA, 1'b0);
    applystimulus(8'hF0, 1'b0);
    in_data  = 8'hFF;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkoutput("t3 hold valid", {31'd0, out_valid}, 32'd1);
      checkoutput("t3 hold data", out_data, 32'hCDDEAAF0);
      checkoutput("t3 in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    idle(2);

    // 4: back-to-back words, last byte of second word also carries in_last
    stalls = 0;
    expectword(32'h10111213, 4'hF, 1'b0);
    expectword(32'h14151617, 4'hF, 1'b1);
    for (int i = 0; i < 8; i++) applystimulus(8'(8'h10 + i), (i == 7));
    checkoutput("t4 stalls", stalls, 32'd0);
    idle(2);

    // 5: single-byte packet
    expectword(32'hDC000000, 4'h8, 1'b1);
    applystimulus(8'hDC, 1'b1);
    idle(2);

    // 6: reset mid-word and in HOLD
    applystimulus(8'h55, 1'b0);
    applystimulus(8'h66, 1'b0);
    pulsereset();
    checkreset("t6 mid-word");
    out_ready = 1'b0;
    applystimulus(8'h77, 1'b0);
    applystimulus(8'h88, 1'b0);
    applystimulus(8'h99, 1'b0);
    applystimulus(8'hAB, 1'b0);
    @(negedge clk);
    checkoutput("t6 hold before reset", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    pulsereset();
    checkreset("t6 hold");
    out_ready = 1'b1;
    expectword(32'h01234567, 4'hF, 1'b0);
    applystimulus(8'h01, 1'b0);
    applystimulus(8'h23, 1'b0);
    applystimulus(8'h45, 1'b0);
    applystimulus(8'h67, 1'b0);
    idle(3);

    checkoutput("scoreboard empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
